fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the width of RD_DATA and OUT_DATA.
REQ-002: Parameter CNT_WIDTH, default 16, SHALL set the width of POP_CNT.
REQ-003: R_CLK  input  1  SHALL be the single clock; every register SHALL update on its rising edge.
REQ-004: R_RST  input  1  SHALL be the reset, synchronous and active-low.
REQ-005: EMPTY  input  1  SHALL be the FIFO empty flag from the FIFO read side.
REQ-006: RD_DATA  input  DATA_WIDTH  SHALL be the FIFO head word, valid whenever EMPTY=0.
REQ-007: R_INC  output  1  SHALL be the FIFO pop request.
REQ-008: FLUSH  input  1  SHALL request a synchronous discard of all buffered words.
REQ-009: OUT_DATA  output  DATA_WIDTH  SHALL be the stream data.
REQ-010: OUT_VALID  output  1  SHALL qualify OUT_DATA.
REQ-011: OUT_READY  input  1  SHALL be the downstream acceptance signal.
REQ-012: POP_CNT  output  CNT_WIDTH  SHALL be the count of words popped from the FIFO (see Configuration).

Function
REQ-013: The block SHALL hold a 2-entry buffer made of a head register (drives OUT_DATA) and a skid register, with states S_EMPTY (0 words), S_ONE (1 word) and S_TWO (2 words).
REQ-014: R_INC SHALL be driven as EMPTY=0 AND state!=S_TWO AND FLUSH=0, and SHALL depend only on registered state, EMPTY and FLUSH, never on OUT_READY.
REQ-015: A pop (R_INC=1 in cycle n) SHALL capture RD_DATA at the cycle n edge; the word SHALL be visible on OUT_DATA with OUT_VALID=1 in cycle n+1 when the buffer was empty (1-cycle latency).
REQ-016: A transfer SHALL occur when OUT_VALID=1 and OUT_READY=1; OUT_DATA and OUT_VALID SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-017: Transitions: S_EMPTY+pop to S_ONE; S_ONE+pop without transfer to S_TWO; S_ONE+transfer without pop to S_EMPTY; S_ONE+pop+transfer stays S_ONE with the new word in the head; S_TWO+transfer to S_ONE with the skid word moved to the head; all other cases hold.
REQ-018: Words SHALL leave in exactly the order popped, with no loss or duplication.
REQ-019: With OUT_READY held at 1 and EMPTY held at 0, the block SHALL sustain one transfer per cycle.
REQ-020: In S_TWO, R_INC SHALL be 0 even if OUT_READY=1 in the same cycle.
REQ-021: OUT_VALID SHALL be 1 exactly when state is S_ONE or S_TWO.
REQ-022: FLUSH=1 SHALL take priority over pop and transfer: the state SHALL become S_EMPTY at the next edge and OUT_VALID SHALL be 0 in the following cycle; no word SHALL be popped in a FLUSH cycle.
REQ-023: POP_CNT SHALL increment by 1 on every edge where R_INC=1, SHALL wrap from all-ones to 0, and SHALL be unaffected by FLUSH.

Reset
REQ-024: While R_RST=0 at a rising edge, the state SHALL become S_EMPTY, OUT_VALID SHALL be 0, OUT_DATA SHALL be 0, the skid register SHALL be 0 and POP_CNT SHALL be 0.
REQ-025: R_INC SHALL be 0 in any cycle in which R_RST=0; reset SHALL override FLUSH and an in-progress transfer, and buffered words SHALL be discarded.

Configuration
REQ-026: With macro FIFO_RD_STREAM_POP_CNT_EN defined, POP_CNT SHALL be implemented per REQ-023.
REQ-027: Without FIFO_RD_STREAM_POP_CNT_EN, the POP_CNT port SHALL remain present, SHALL be tied to 0 and SHALL contain no counter register; all other behaviour SHALL be identical.

Verification
REQ-028: Reset with EMPTY=0 and RD_DATA=8'hA5, then release -> R_INC=0 during reset; R_INC=1 in the first cycle after release; OUT_VALID=1 with OUT_DATA=8'hA5 in the next cycle.
REQ-029: FIFO supplies 0x01..0x10 and OUT_READY=1 constantly -> 16 transfers in 16 consecutive cycles, in order; POP_CNT=16.
REQ-030: OUT_READY=0 while words 0x11 and 0x22 are available -> state S_TWO, R_INC=0, OUT_DATA=0x11 stable; after OUT_READY=1 -> 0x11, then 0x22, transferred on consecutive cycles.
REQ-031: FLUSH=1 for one cycle in S_TWO -> OUT_VALID=0 in the next cycle, no R_INC in the FLUSH cycle, POP_CNT unchanged; the next pop delivers a new word.
REQ-032: POP_CNT preset by 65535 pops, then one more pop -> POP_CNT=0 (macro defined); with the macro undefined -> POP_CNT=0 throughout.
REQ-033: EMPTY toggles 1/0 every cycle with OUT_READY random -> every popped word is delivered exactly once, in order, and R_INC is never 1 while EMPTY=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Two-entry skid buffer that turns a FIFO read port into a valid/ready stream.
// Define FIFO_RD_STREAM_POP_CNT_EN to implement the POP_CNT counter; otherwise it is tied to 0.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  R_INC,
   input  logic                  FLUSH,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [CNT_WIDTH-1:0]  POP_CNT
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  out_valid_q;
   logic                  xfer;

   // Pop decision never looks at OUT_READY, so the skid slot always has room for the popped word.
   assign R_INC     = R_RST && !EMPTY && (state != S_TWO) && !FLUSH;
   assign xfer      = out_valid_q && OUT_READY;
   assign OUT_DATA  = head_q;
   assign OUT_VALID = out_valid_q;

   always_ff @(posedge R_CLK) begin
      if (!R_RST) begin
         state       <= S_EMPTY;
         head_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
      end else if (FLUSH) begin
         state       <= S_EMPTY;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (R_INC) begin
                  head_q      <= RD_DATA;
                  state       <= S_ONE;
                  out_valid_q <= 1'b1;
               end
            end
            S_ONE: begin
               if (R_INC && xfer) begin
                  head_q <= RD_DATA;
               end else if (R_INC) begin
                  skid_q <= RD_DATA;
                  state  <= S_TWO;
               end else if (xfer) begin
                  state       <= S_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            S_TWO: begin
               if (xfer) begin
                  head_q <= skid_q;
                  state  <= S_ONE;
               end
            end
            default: begin
               state       <= S_EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_POP_CNT_EN
   logic [CNT_WIDTH-1:0] pop_cnt_q;

   // Free-running pop count; wraps naturally and ignores FLUSH.
   always_ff @(posedge R_CLK) begin
      if (!R_RST) begin
         pop_cnt_q <= '0;
      end else if (R_INC) begin
         pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign POP_CNT = pop_cnt_q;
`else
   assign POP_CNT = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized scoreboard bench for fifo_rd_stream: a queue-based FIFO source model feeds the DUT
// and every popped word must leave the stream exactly once, in order.
module tb_fifo_rd_stream;

   localparam int DW = 8;
   localparam int CW = 16;

   logic          R_CLK = 1'b0;
   logic          R_RST = 1'b0;
   logic          EMPTY = 1'b1;
   logic          FLUSH = 1'b0;
   logic          OUT_READY = 1'b0;
   logic [DW-1:0] RD_DATA = '0;
   logic          R_INC;
   logic          OUT_VALID;
   logic [DW-1:0] OUT_DATA;
   logic [CW-1:0] POP_CNT;

   int            checks = 0;
   int            failures = 0;
   int            xfer_count = 0;
   logic [DW-1:0] srcq[$];
   logic [DW-1:0] expq[$];
   logic [CW-1:0] pop_model = '0;
   logic          known = 1'b0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .R_CLK(R_CLK), .R_RST(R_RST), .EMPTY(EMPTY), .RD_DATA(RD_DATA), .R_INC(R_INC),
      .FLUSH(FLUSH), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .POP_CNT(POP_CNT)
   );

   always #5 R_CLK = ~R_CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
      end
   endtask

   function automatic logic [CW-1:0] expCnt();
`ifdef FIFO_RD_STREAM_POP_CNT_EN
      return pop_model;
`else
      return '0;
`endif
   endfunction

   // One clock cycle: drive inputs at the falling edge, then apply the occupancy-level model.
   task automatic applyStimulus(input logic rst, input logic avail, input logic flush, input logic ready);
      logic exp_inc;
      @(negedge R_CLK);
      R_RST     = rst;
      FLUSH     = flush;
      OUT_READY = ready;
      EMPTY     = !(avail && srcq.size() > 0);
      RD_DATA   = EMPTY ? DW'($urandom) : srcq[0];
      #1;
      exp_inc = rst && !EMPTY && (expq.size() < 2) && !flush;
      checkOutput("r_inc", {31'd0, R_INC}, {31'd0, exp_inc});
      if (known) begin
         checkOutput("out_valid", {31'd0, OUT_VALID}, {31'd0, expq.size() != 0});
         checkOutput("pop_cnt", {16'd0, POP_CNT}, {16'd0, expCnt()});
         if (prev_hold) checkOutput("hold_data", {24'd0, OUT_DATA}, {24'd0, prev_data});
      end
      prev_hold = rst && !flush && (expq.size() != 0) && !ready;
      prev_data = OUT_DATA;
      if (!rst) begin
         expq.delete();
         pop_model = '0;
         known     = 1'b1;
      end else if (flush) begin
         expq.delete();
      end
      if (exp_inc) begin
         expq.push_back(srcq.pop_front());
         pop_model++;
      end
   endtask

   // Monitor: every accepted transfer must match the oldest popped word.
   always @(negedge R_CLK) begin
      #2;
      if (R_RST && !FLUSH && OUT_VALID === 1'b1 && OUT_READY) begin
         if (expq.size() == 0) begin
            checkOutput("xfer_without_word", {31'd0, OUT_VALID}, 32'd0);
         end else begin
            checkOutput("xfer_data", {24'd0, OUT_DATA}, {24'd0, expq.pop_front()});
            xfer_count++;
         end
      end
   end

   task automatic doReset();
      srcq.delete();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int start;
      int guard;

      // Word waiting during reset is popped right after release and shown one cycle later.
      srcq.push_back(8'hA5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("latency_valid", {31'd0, OUT_VALID}, 32'd1);
      checkOutput("latency_data", {24'd0, OUT_DATA}, 32'hA5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

      // Back-to-back streaming of 0x01..0x10.
      doReset();
      for (int i = 1; i <= 16; i++) srcq.push_back(DW'(i));
      start = xfer_count;
      for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("stream_xfers", xfer_count - start, 32'd16);
`ifdef FIFO_RD_STREAM_POP_CNT_EN
      checkOutput("stream_pop_cnt", {16'd0, POP_CNT}, 32'd16);
`else
      checkOutput("stream_pop_cnt", {16'd0, POP_CNT}, 32'd0);
`endif

      // Backpressure fills both slots; the head must stay 0x11.
      doReset();
      srcq.push_back(8'h11); srcq.push_back(8'h22); srcq.push_back(8'h33);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("full_head", {24'd0, OUT_DATA}, 32'h11);
      checkOutput("full_no_pop", {31'd0, R_INC}, 32'd0);
      start = xfer_count;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("drain_xfers", xfer_count - start, 32'd3);

      // Flush while full, then a fresh word must come through.
      doReset();
      srcq.push_back(8'h44); srcq.push_back(8'h55); srcq.push_back(8'h66);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("flush_valid", {31'd0, OUT_VALID}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("after_flush_data", {24'd0, OUT_DATA}, 32'h66);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

      // Random traffic: EMPTY toggling, random ready, occasional flush and reset.
      doReset();
      for (int i = 0; i < 600; i++) begin
         if (srcq.size() < 4) srcq.push_back(DW'($urandom));
         applyStimulus(($urandom_range(0, 199) != 0), i[0], ($urandom_range(0, 31) == 0),
                       1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("random_drained", expq.size(), 32'd0);

      // Counter wrap after 65535 pops.
      doReset();
      guard = 0;
      while (pop_model != 16'hFFFF && guard < 70000) begin
         if (srcq.size() < 3) srcq.push_back(DW'($urandom));
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
         guard++;
      end
      checkOutput("wrap_reached", {31'd0, pop_model == 16'hFFFF}, 32'd1);
      if (srcq.size() < 3) srcq.push_back(DW'($urandom));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_RD_STREAM_POP_CNT_EN
      checkOutput("cnt_all_ones", {16'd0, POP_CNT}, 32'hFFFF);
`else
      checkOutput("cnt_all_ones", {16'd0, POP_CNT}, 32'd0);
`endif
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("cnt_wrap", {16'd0, POP_CNT}, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
